// File: rtl/nvdla_cacc_reg_initiator_pkg.sv
// Shared types for the CACC register-bus initiator: op codes, FSM states,
// the buffered request payload and the masked poll compare.
package nvdla_cacc_reg_initiator_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'd0,
    OP_RD   = 2'd1,
    OP_POLL = 2'd2,
    OP_RSV  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_POLL = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // 2 + 12 + 32 + 32 = 78 bits
  typedef struct packed {
    op_e         op;
    logic [11:0] offset;
    logic [31:0] wdata;
    logic [31:0] mask;
  } req_t;

  function automatic logic poll_hit(input logic [31:0] sample,
                                    input logic [31:0] expect_val,
                                    input logic [31:0] mask);
    return (sample & mask) == (expect_val & mask);
  endfunction

endpackage

// File: rtl/nvdla_cacc_reg_req_fifo.sv
// Request FIFO for the register initiator: REQ_DEPTH entries, no bypass,
// so a push into an empty FIFO is poppable on the following cycle.
module nvdla_cacc_reg_req_fifo
  import nvdla_cacc_reg_initiator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  req_t        mem [DEPTH];

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/nvdla_cacc_reg_initiator.sv
// Register-bus initiator for the CACC register file. Poll support (with
// timeout) is built only when NVDLA_CACC_REG_POLL_EN is defined.
module nvdla_cacc_reg_initiator
  import nvdla_cacc_reg_initiator_pkg::*;
#(
  parameter int REQ_DEPTH    = 4,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        req_pvld,
  output logic        req_prdy,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_mask,
  output logic        rsp_pvld,
  input  logic        rsp_prdy,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [11:0] reg_offset,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  input  logic [31:0] reg_rd_data,
  output logic        busy
);

  req_t   push_data;
  req_t   head;
  logic   full;
  logic   empty;
  logic   pop;
  state_e state;

  assign push_data = '{op: op_e'(req_op), offset: req_offset, wdata: req_wdata, mask: req_mask};
  assign req_prdy  = ~full;
  assign pop       = ((state == ST_IDLE) || (state == ST_WR)) && !empty;
  assign busy      = (state != ST_IDLE) || !empty;

  nvdla_cacc_reg_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (req_pvld & ~full),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

`ifdef NVDLA_CACC_REG_POLL_EN
  localparam int CW = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  logic [CW-1:0] poll_cnt;
  logic [31:0]   poll_exp;
  logic [31:0]   poll_mask;
`else
  logic unused_poll;
  assign unused_poll = ^{req_mask, head.mask, 32'(POLL_TIMEOUT)};
`endif

  // Access sequencer; all bus and response outputs are flopped here.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state       <= ST_IDLE;
      reg_offset  <= 12'd0;
      reg_wr_data <= 32'd0;
      reg_wr_en   <= 1'b0;
      rsp_pvld    <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
`ifdef NVDLA_CACC_REG_POLL_EN
      poll_cnt    <= '0;
      poll_exp    <= 32'd0;
      poll_mask   <= 32'd0;
`endif
    end else begin
      reg_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_WR: begin
          if (!empty) begin
            reg_offset <= head.offset;
            case (head.op)
              OP_WR: begin
                reg_wr_data <= head.wdata;
                reg_wr_en   <= 1'b1;
                state       <= ST_WR;
              end
              OP_RD: state <= ST_RD;
`ifdef NVDLA_CACC_REG_POLL_EN
              OP_POLL: begin
                poll_cnt  <= '0;
                poll_exp  <= head.wdata;
                poll_mask <= head.mask;
                state     <= ST_POLL;
              end
`else
              OP_POLL: state <= ST_RD;
`endif
              default: begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b1;
                rsp_pvld  <= 1'b1;
                state     <= ST_RESP;
              end
            endcase
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RD: begin
          rsp_rdata <= reg_rd_data;
          rsp_err   <= 1'b0;
          rsp_pvld  <= 1'b1;
          state     <= ST_RESP;
        end
`ifdef NVDLA_CACC_REG_POLL_EN
        ST_POLL: begin
          if (poll_hit(reg_rd_data, poll_exp, poll_mask)) begin
            rsp_rdata <= reg_rd_data;
            rsp_err   <= 1'b0;
            rsp_pvld  <= 1'b1;
            state     <= ST_RESP;
          end else if (poll_cnt == CW'(POLL_TIMEOUT - 1)) begin
            rsp_rdata <= reg_rd_data;
            rsp_err   <= 1'b1;
            rsp_pvld  <= 1'b1;
            state     <= ST_RESP;
          end else begin
            poll_cnt <= poll_cnt + CW'(1);
          end
        end
`endif
        ST_RESP: begin
          if (rsp_prdy) begin
            rsp_pvld <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            rsp_pvld <= 1'b1;
          end
        end
        default: begin
          rsp_pvld <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_cacc_reg_initiator.sv
// Self-checking bench for nvdla_cacc_reg_initiator: directed scenarios plus
// randomized single transactions checked against a request-level model.
module tb_nvdla_cacc_reg_initiator;

  localparam int T     = 16;
  localparam int DEPTH = 4;
`ifdef NVDLA_CACC_REG_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_pvld;
  logic        req_prdy;
  logic [1:0]  req_op;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic [31:0] req_mask;
  logic        rsp_pvld;
  logic        rsp_prdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  logic        busy;
  logic        rd_mode;
  logic [31:0] rd_drv;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // In rd_mode the register file returns a value derived from the offset.
  assign reg_rd_data = rd_mode ? {20'h5A5A5, reg_offset} : rd_drv;

  nvdla_cacc_reg_initiator #(.REQ_DEPTH(DEPTH), .POLL_TIMEOUT(T)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .req_pvld       (req_pvld),
    .req_prdy       (req_prdy),
    .req_op         (req_op),
    .req_offset     (req_offset),
    .req_wdata      (req_wdata),
    .req_mask       (req_mask),
    .rsp_pvld       (rsp_pvld),
    .rsp_prdy       (rsp_prdy),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .reg_offset     (reg_offset),
    .reg_wr_data    (reg_wr_data),
    .reg_wr_en      (reg_wr_en),
    .reg_rd_data    (reg_rd_data),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register value seen on poll sample j when it starts matching at sample k.
  function automatic logic [31:0] samp(input int j, input int k,
                                       input logic [31:0] good, input logic [31:0] bad);
    return (j >= k) ? good : bad;
  endfunction

  // Request-level model: edges after the push edge until the response is
  // visible (-1 = none), plus its payload.
  task automatic model(input logic [1:0] op, input logic [31:0] wdata, input logic [31:0] mask,
                       input logic [31:0] good, input logic [31:0] bad, input int k,
                       output int lat, output logic [31:0] rdata, output logic err);
    bit hit = 1'b0;
    lat = -1; rdata = 32'd0; err = 1'b0;
    if (op == 2'd0) begin
      lat = -1;
    end else if (op == 2'd3) begin
      lat = 1; err = 1'b1;
    end else if (op == 2'd1 || !POLL_EN) begin
      lat = 2; rdata = samp(0, k, good, bad);
    end else begin
      lat = T + 1; err = 1'b1; rdata = samp(T - 1, k, good, bad);
      for (int j = 0; j < T; j++) begin
        if (!hit && ((samp(j, k, good, bad) & mask) == (wdata & mask))) begin
          hit = 1'b1; lat = 2 + j; rdata = samp(j, k, good, bad); err = 1'b0;
        end
      end
    end
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [11:0] off, input logic [31:0] wdata,
                        input logic [31:0] mask, input logic [31:0] good, input logic [31:0] bad,
                        input int k);
    int lat; logic [31:0] erd; logic eerr;
    int rsp_edge = -1; int rsp_cnt = 0; int wr_edge = -1; int wr_cnt = 0;
    logic [31:0] got_rd = 32'd0; logic got_err = 1'b0; logic [31:0] got_wd = 32'd0;
    model(op, wdata, mask, good, bad, k, lat, erd, eerr);
    rd_mode = 1'b0; rd_drv = bad; rsp_prdy = 1'b1;
    @(posedge clk); #1;
    req_pvld = 1'b1; req_op = op; req_offset = off; req_wdata = wdata; req_mask = mask;
    check("prdy_idle", 32'(req_prdy), 32'd1);
    @(posedge clk); #1;
    req_pvld = 1'b0;
    for (int e = 1; e <= T + 6; e++) begin
      @(posedge clk); #1;
      rd_drv = samp(e - 1, k, good, bad);
      @(negedge clk);
      if (reg_wr_en) begin
        wr_cnt++;
        if (wr_edge < 0) begin wr_edge = e; got_wd = reg_wr_data; end
      end
      if (rsp_pvld) begin
        rsp_cnt++;
        if (rsp_edge < 0) begin rsp_edge = e; got_rd = rsp_rdata; got_err = rsp_err; end
      end
    end
    check("txn_offset", 32'(reg_offset), 32'(off));
    if (op == 2'd0) begin
      check("wr_edge", 32'(wr_edge), 32'd1);
      check("wr_cnt", 32'(wr_cnt), 32'd1);
      check("wr_data", got_wd, wdata);
      check("wr_no_rsp", 32'(rsp_cnt), 32'd0);
    end else begin
      check("rsp_edge", 32'(rsp_edge), 32'(lat));
      check("rsp_cnt", 32'(rsp_cnt), 32'd1);
      check("rsp_rdata", got_rd, erd);
      check("rsp_err", 32'(got_err), 32'(eerr));
      check("rd_no_wr", 32'(wr_cnt), 32'd0);
    end
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int wr_cyc[$];
    logic [43:0] wr_dat[$];
    logic [32:0] rsp_q[$];
    logic [43:0] exp_w [3];
    logic [31:0] held;
    logic [1:0]  f_op [4];
    logic [11:0] f_off [4];
    int rsp_seen;

    rstn = 1'b0; req_pvld = 1'b0; req_op = 2'd0; req_offset = 12'd0; req_wdata = 32'd0;
    req_mask = 32'd0; rsp_prdy = 1'b1; rd_mode = 1'b0; rd_drv = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_offset", 32'(reg_offset), 32'd0);
    check("rst_wdata", reg_wr_data, 32'd0);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_pvld", 32'(rsp_pvld), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prdy", 32'(req_prdy), 32'd1);
    rstn = 1'b1;

    // Three back-to-back writes: strobes on three consecutive cycles.
    exp_w[0] = {12'h01c, 32'd5}; exp_w[1] = {12'h02c, 32'd3}; exp_w[2] = {12'h008, 32'd1};
    rsp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        req_pvld = 1'b1; req_op = 2'd0; req_offset = exp_w[i][43:32]; req_wdata = exp_w[i][31:0];
      end else begin
        req_pvld = 1'b0;
      end
      @(negedge clk);
      if (reg_wr_en) begin wr_cyc.push_back(i); wr_dat.push_back({reg_offset, reg_wr_data}); end
      if (rsp_pvld) rsp_seen++;
    end
    check("b2b_count", 32'(wr_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_cyc.size(); i++) begin
      check("b2b_cycle", 32'(wr_cyc[i]), 32'(2 + i));
      check("b2b_off", 32'(wr_dat[i][43:32]), 32'(exp_w[i][43:32]));
      check("b2b_data", wr_dat[i][31:0], exp_w[i][31:0]);
    end
    check("b2b_no_rsp", 32'(rsp_seen), 32'd0);

    // Directed read, polls, reserved op.
    do_txn(2'd1, 12'h00c, 32'd0, 32'd0, 32'h0000_1001, 32'hDEAD_BEEF, 0);
    do_txn(2'd2, 12'h008, 32'd1, 32'd1, 32'd1, 32'd0, 5);
    do_txn(2'd2, 12'h008, 32'd1, 32'd1, 32'd1, 32'd0, 1000);
    do_txn(2'd2, 12'h010, 32'h1234_5678, 32'd0, 32'd7, 32'hFFFF_0000, 9);
    do_txn(2'd3, 12'h014, 32'hFFFF_FFFF, 32'd0, 32'd9, 32'd9, 0);

    // Randomized single transactions.
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  op;
      logic [31:0] wd, mk, gd, bd;
      op = 2'($urandom_range(0, 3));
      wd = $urandom;
      case ($urandom_range(0, 2))
        0: mk = 32'd0;
        1: mk = 32'd1 << $urandom_range(0, 31);
        default: mk = $urandom;
      endcase
      gd = (wd & mk) | ($urandom & ~mk);
      bd = $urandom;
      do_txn(op, 12'($urandom), wd, mk, gd, bd, $urandom_range(0, T + 2));
    end

    // Backpressure: hold a response, fill the FIFO, then drain in order.
    rd_mode = 1'b1; rsp_prdy = 1'b0;
    @(posedge clk); #1;
    req_pvld = 1'b1; req_op = 2'd1; req_offset = 12'h100;
    @(posedge clk); #1;
    req_pvld = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_pvld", 32'(rsp_pvld), 32'd1);
    check("bp_rdata", rsp_rdata, 32'h5A5A_5100);
    held = rsp_rdata;
    f_op[0] = 2'd1; f_off[0] = 12'h104;
    f_op[1] = 2'd0; f_off[1] = 12'h108;
    f_op[2] = 2'd1; f_off[2] = 12'h10c;
    f_op[3] = 2'd3; f_off[3] = 12'h110;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_pvld = 1'b1; req_op = f_op[i]; req_offset = f_off[i]; req_wdata = 32'hCAFE_0000 + 32'(i);
      @(negedge clk);
      check("fill_prdy", 32'(req_prdy), 32'd1);
    end
    @(posedge clk); #1;
    req_pvld = 1'b0;
    check("full_prdy", 32'(req_prdy), 32'd0);
    repeat (3) @(negedge clk);
    check("full_prdy_hold", 32'(req_prdy), 32'd0);
    check("hold_pvld", 32'(rsp_pvld), 32'd1);
    check("hold_rdata", rsp_rdata, held);
    wr_dat.delete();
    @(posedge clk); #1;
    rsp_prdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_pvld && rsp_prdy) rsp_q.push_back({rsp_err, rsp_rdata});
      if (reg_wr_en) wr_dat.push_back({reg_offset, reg_wr_data});
      @(posedge clk);
    end
    check("drain_rsp_cnt", 32'(rsp_q.size()), 32'd4);
    if (rsp_q.size() == 4) begin
      check("drain_rsp0", 32'(rsp_q[0]), 32'h5A5A_5100);
      check("drain_rsp1", 32'(rsp_q[1]), 32'h5A5A_5104);
      check("drain_rsp2", 32'(rsp_q[2]), 32'h5A5A_510c);
      check("drain_rsp3_err", 32'(rsp_q[3][32]), 32'd1);
      check("drain_rsp3_data", rsp_q[3][31:0], 32'd0);
    end
    check("drain_wr_cnt", 32'(wr_dat.size()), 32'd1);
    if (wr_dat.size() == 1) check("drain_wr", wr_dat[0][31:0] ^ 32'(wr_dat[0][43:32]), 32'hCAFE_0001 ^ 32'h108);
    check("drain_busy", 32'(busy), 32'd0);

    // Reset during WR with a second write still queued.
    rd_mode = 1'b0;
    @(posedge clk); #1;
    req_pvld = 1'b1; req_op = 2'd0; req_offset = 12'h020; req_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    req_offset = 12'h024; req_wdata = 32'h2222_2222;
    @(posedge clk); #1;
    req_pvld = 1'b0;
    check("pre_rst_wr_en", 32'(reg_wr_en), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("async_wr_en", 32'(reg_wr_en), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_prdy", 32'(req_prdy), 32'd1);
    check("async_pvld", 32'(rsp_pvld), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    wr_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (reg_wr_en || busy) wr_cyc.push_back(i);
    end
    check("post_rst_quiet", 32'(wr_cyc.size()), 32'd0);
    check("post_rst_offset", 32'(reg_offset), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nvdla_cacc_reg_initiator.md
# nvdla_cacc_reg_initiator

Register-bus initiator for the CACC register file. It accepts buffered write, read and poll requests on a valid/ready channel. It drives the single-cycle register interface (reg_offset / reg_wr_data / reg_wr_en, combinational reg_rd_data) one access at a time, and returns read and poll results on a response channel. It sits between the CSB/config-sequencer side and the CACC dual register file, and lets firmware-less test sequences program a layer and wait on op_en.

## Interface
- REQ_DEPTH, 4: request FIFO entries (power of two, ≥2)
- POLL_TIMEOUT, 1024: maximum non-matching poll samples before error
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- req_pvld  in  1  request valid
- req_prdy  out  1  request ready (= FIFO not full)
- req_op  in  2  0 write, 1 read, 2 poll, 3 reserved
- req_offset  in  12  register byte offset
- req_wdata  in  32  write data / poll expected value
- req_mask  in  32  poll compare mask (ignored otherwise)
- rsp_pvld  out  1  response valid
- rsp_prdy  in  1  response ready
- rsp_rdata  out  32  read/poll sampled data
- rsp_err  out  1  poll timeout or reserved op
- reg_offset  out  12  register offset, flopped
- reg_wr_data  out  32  register write data, flopped
- reg_wr_en  out  1  one-cycle write strobe, flopped
- reg_rd_data  in  32  combinational read data for reg_offset
- busy  out  1  FSM not IDLE or FIFO non-empty

Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous and active-low.

## Operation
- Handshake: a request is pushed when req_pvld & req_prdy. A response is consumed when rsp_pvld & rsp_prdy. rsp_pvld and the response payload stay stable until consumed.
- Writes are posted and produce no response. Read, poll and reserved requests each produce exactly one response, in request order.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, load reg_offset, and go by op: write → WR (reg_wr_data loaded, reg_wr_en=1); read → RD; poll → POLL (counter cleared); reserved → RESP (err=1, rdata=0).
  - WR: reg_wr_en is high for exactly this cycle. If the FIFO is non-empty, pop the next request as in IDLE (back-to-back writes, one per cycle). Otherwise go to IDLE.
  - RD: capture reg_rd_data into rsp_rdata with err=0, then go to RESP.
  - POLL: each cycle, compare (reg_rd_data & req_mask) == (req_wdata & req_mask).
    - Match: rdata=sample, err=0, go to RESP.
    - No match: counter++. When the counter reaches POLL_TIMEOUT−1 on a mismatch, go to RESP with err=1 and rdata=last sample.
  - RESP: rsp_pvld=1. On rsp_prdy, go to IDLE. No new pop happens while in RESP.
- reg_offset and reg_wr_data hold their last value outside accesses. reg_wr_en is 0 outside WR.
- mask=0 makes a poll match on its first sample.
- Full FIFO: req_prdy=0. Empty FIFO in IDLE: no bus activity. A push and a pop in the same cycle are allowed when the FIFO is not full.
- Reset mid-operation: FIFO is flushed, FSM goes to IDLE, reg_wr_en is deasserted immediately (asynchronously), and any pending response is dropped.
- Reset values: reg_offset=0, reg_wr_data=0, reg_wr_en=0, rsp_pvld=0, rsp_rdata=0, rsp_err=0, busy=0, req_prdy=1.

## Timing
- Write: pushed at cycle N. In an idle block it is popped at N+1 and reg_wr_en is high during N+2 (a FIFO-latency of 1).
- Read: pushed at N. reg_offset is valid at N+2 (RD state), rsp_pvld at N+3.
- Poll matching on sample k (k=0 first): rsp_pvld at N+3+k.
- Poll timeout: rsp_pvld at N+2+POLL_TIMEOUT.
- Sustained write throughput: one write per cycle. A read costs 3 cycles minimum including RESP.

## Configuration
- NVDLA_CACC_REG_POLL_EN defined: poll op is implemented as above, including the timeout counter of width $clog2(POLL_TIMEOUT).
- Not defined: op 2 behaves as a read (single sample, err=0). The POLL state and counter are not built. req_mask is unused.

## Structure
- Shared package: op encodings (OP_WR, OP_RD, OP_POLL, OP_RSV), FSM state enum, and request payload struct (op, offset, wdata, mask; 78 bits).
- One sub-module: nvdla_cacc_reg_req_fifo. It is a synchronous FIFO of REQ_DEPTH payload entries with full/empty outputs, asynchronous active-low reset, and no bypass.

## Test plan
- Three back-to-back writes (0x01c←5, 0x02c←3, 0x008←1) → reg_wr_en high on three consecutive cycles with matching offset/data; no responses.
- Read 0x00c with reg_rd_data=0x1001 → one response, rdata=0x00001001, err=0, at N+3.
- Poll 0x008, mask=1, expect=1; reg_rd_data goes to 1 on the 6th sample → rsp at N+8, rdata=1, err=0.
- Poll never matching with POLL_TIMEOUT=16 → rsp_err=1 at N+18. Reserved op → immediate response with err=1, rdata=0.
- Fill 4 requests while rsp_prdy=0 → req_prdy drops after the 4th. rsp_pvld is held stable until rsp_prdy, then the remaining requests drain in order.
- Assert nvdla_core_rstn during the WR state → reg_wr_en is 0 immediately, FIFO is empty after release, busy=0, req_prdy=1.
